// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state/owner types and counter width helper for mem_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_D  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int DEF_MAX_WAIT = 3;
    localparam int DEF_TIMEOUT  = 15;

    // Bits needed to hold 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear and at-limit flag
module sat_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 15
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != LIMIT_V)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_limit_o = (count_q == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port memory bus between fetch and load/store ports
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_ack_o,
    output logic                if_err_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_ack_o,
    output logic                d_err_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int BE_W    = DATA_W / 8;
    localparam int STARV_W = cnt_width(MAX_WAIT);
    localparam int TMO_W   = cnt_width(TIMEOUT);

    arb_state_e        state_q, state_d;
    owner_e            owner;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              starv_at_limit, starv_clr, starv_inc;
    logic              tmo_at_limit, tmo_clr;
    logic              busy, done, timed_out, ok_ack;

    assign busy      = (state_q != ST_IDLE);
    assign owner     = (state_q == ST_BUSY_D) ? OWN_D : OWN_IF;
    // A memory ack in the timeout cycle takes precedence over the error.
    assign done      = busy && (mem_ack_i || tmo_at_limit);
    assign timed_out = busy && tmo_at_limit && !mem_ack_i;
    assign ok_ack    = busy && mem_ack_i;
    assign tmo_clr   = !busy || done;

    sat_counter #(.WIDTH(STARV_W), .LIMIT(MAX_WAIT)) u_starv (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .clr_i      (starv_clr),
        .inc_i      (starv_inc),
        .at_limit_o (starv_at_limit)
    );

    sat_counter #(.WIDTH(TMO_W), .LIMIT(TIMEOUT)) u_tmo (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .clr_i      (tmo_clr),
        .inc_i      (busy),
        .at_limit_o (tmo_at_limit)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        starv_clr   = 1'b0;
        starv_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (if_req_i && (!d_req_i || starv_at_limit)) begin
                    state_d     = ST_BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                    starv_clr   = 1'b1;
                end else if (d_req_i) begin
                    state_d     = ST_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we_i;
                    mem_be_d    = d_be_i;
                    mem_addr_d  = d_addr_i;
                    mem_wdata_d = d_wdata_i;
                    starv_inc   = if_req_i;
                end
            end
            default: begin
                if (done) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    assign if_ack_o   = done && (owner == OWN_IF);
    assign if_err_o   = timed_out && (owner == OWN_IF);
    assign if_rdata_o = (ok_ack && (owner == OWN_IF)) ? mem_rdata_i : '0;
    assign d_ack_o    = done && (owner == OWN_D);
    assign d_err_o    = timed_out && (owner == OWN_D);
    assign d_rdata_o  = (ok_ack && (owner == OWN_D)) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a behavioural model
module tb_mem_arbiter;

    localparam int MAX_WAIT = 3;
    localparam int TIMEOUT  = 15;

    logic        clock_i, reset_i;
    logic        if_req_i, if_ack_o, if_err_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        d_req_i, d_we_i, d_ack_o, d_err_o;
    logic [3:0]  d_be_i;
    logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int total = 0;
    int bad   = 0;
    int starv_m = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_ack_o    (if_ack_o),
        .if_err_o    (if_err_o),
        .if_rdata_o  (if_rdata_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_be_i      (d_be_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_ack_o     (d_ack_o),
        .d_err_o     (d_err_o),
        .d_rdata_o   (d_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1 of an IDLE cycle with requests already driven.
    // lat = BUSY cycle in which memory acks (beyond TIMEOUT means never).
    task automatic run_txn(input int lat, input logic [31:0] rd, output bit got_if);
        bit          exp_if, exp_err, done;
        int          ack_cyc, cyc;
        logic [31:0] exp_addr, exp_wd;
        logic        exp_we;
        logic [3:0]  exp_be;
        got_if      = 1'b0;
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        #3;
        chk("idle_req", 32'(mem_req_o), 32'd0);
        chk("idle_ack", 32'({if_ack_o, d_ack_o, if_err_o, d_err_o}), 32'd0);
        exp_if = if_req_i && (!d_req_i || starv_m == MAX_WAIT);
        exp_wd = d_wdata_i;
        if (exp_if) begin
            starv_m  = 0;
            exp_addr = if_addr_i;
            exp_we   = 1'b0;
            exp_be   = 4'hF;
        end else begin
            if (if_req_i && starv_m < MAX_WAIT) starv_m++;
            exp_addr = d_addr_i;
            exp_we   = d_we_i;
            exp_be   = d_be_i;
        end
        ack_cyc = (lat >= 0 && lat <= TIMEOUT) ? lat : TIMEOUT;
        exp_err = (ack_cyc != lat);
        @(posedge clock_i); #1;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            mem_ack_i   = (cyc == lat);
            mem_rdata_i = (cyc == lat) ? rd : $urandom;
            #3;
            chk("busy_req", 32'(mem_req_o), 32'd1);
            chk("mem_addr", mem_addr_o, exp_addr);
            chk("mem_we", 32'(mem_we_o), 32'(exp_we));
            chk("mem_be", 32'(mem_be_o), 32'(exp_be));
            if (!exp_if && exp_we) chk("mem_wdata", mem_wdata_o, exp_wd);
            if (cyc == ack_cyc) begin
                got_if = if_ack_o;
                chk("own_ack", 32'(exp_if ? if_ack_o : d_ack_o), 32'd1);
                chk("other_ack", 32'(exp_if ? {d_ack_o, d_err_o} : {if_ack_o, if_err_o}), 32'd0);
                chk("own_err", 32'(exp_if ? if_err_o : d_err_o), 32'(exp_err));
                chk("own_rdata", exp_if ? if_rdata_o : d_rdata_o, exp_err ? 32'd0 : rd);
                done = 1'b1;
            end else begin
                chk("no_ack", 32'({if_ack_o, d_ack_o, if_err_o, d_err_o}), 32'd0);
            end
            @(posedge clock_i); #1;
            cyc++;
        end
        chk("txn_bound", 32'(done), 32'd1);
        mem_ack_i = 1'b0;
    endtask

    bit          g;
    bit          order [8];
    logic [31:0] rd;

    initial begin
        reset_i = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        order = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        repeat (2) @(posedge clock_i);
        #3;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_cmd", 32'({mem_we_o, mem_be_o}), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_acks", 32'({if_ack_o, d_ack_o, if_err_o, d_err_o}), 32'd0);
        chk("rst_rdata", if_rdata_o | d_rdata_o, 32'd0);
        @(posedge clock_i); #1;
        reset_i = 1'b1;

        // Lone fetch
        if_req_i = 1'b1; if_addr_i = 32'h40;
        run_txn(2, 32'h00500093, g);
        chk("lone_fetch_owner", 32'(g), 32'd1);
        if_req_i = 1'b0;

        // Store
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'h3; d_addr_i = 32'h100; d_wdata_i = 32'hDEADBEEF;
        run_txn(1, 32'h0, g);
        chk("store_owner", 32'(g), 32'd0);

        // Contention with both requests held continuously
        if_req_i = 1'b1; if_addr_i = 32'h80;
        d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h200;
        for (int i = 0; i < 8; i++) begin
            run_txn(int'($urandom_range(0, 3)), $urandom, g);
            chk("grant_order", 32'(g), 32'(order[i]));
        end
        if_req_i = 1'b0; d_req_i = 1'b0;

        // Timeout on a load, then a normal fetch
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300;
        run_txn(-1, 32'h0, g);
        d_req_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h44;
        run_txn(1, 32'h12345678, g);
        chk("post_tmo_owner", 32'(g), 32'd1);
        if_req_i = 1'b0;

        // Memory ack lands exactly in the timeout cycle: normal completion
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'hC; d_addr_i = 32'h304; d_wdata_i = 32'hCAFEF00D;
        run_txn(TIMEOUT, 32'h0, g);
        d_req_i = 1'b0;

        // Build starvation to the limit, then reset in the middle of a load
        if_req_i = 1'b1; d_req_i = 1'b1; d_we_i = 1'b0;
        for (int i = 0; i < 3; i++) run_txn(0, $urandom, g);
        if_req_i = 1'b0; d_addr_i = 32'h400;
        @(posedge clock_i); #3;
        chk("pre_rst_busy", 32'(mem_req_o), 32'd1);
        @(posedge clock_i); #2;
        reset_i = 1'b0;
        #1;
        chk("rst_async_req", 32'(mem_req_o), 32'd0);
        chk("rst_async_ack", 32'({if_ack_o, d_ack_o}), 32'd0);
        d_req_i = 1'b0;
        starv_m = 0;
        @(posedge clock_i); #1;
        reset_i = 1'b1;
        for (int i = 0; i < TIMEOUT + 3; i++) begin
            #3;
            chk("post_rst_quiet", 32'({mem_req_o, if_ack_o, d_ack_o}), 32'd0);
            @(posedge clock_i); #1;
        end
        if_req_i = 1'b1; d_req_i = 1'b1;
        run_txn(1, $urandom, g);
        chk("post_rst_owner", 32'(g), 32'd0);
        if_req_i = 1'b0; d_req_i = 1'b0;

        // Spurious ack while idle
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
        #3;
        chk("spurious_ack", 32'({if_ack_o, d_ack_o, if_err_o, d_err_o}), 32'd0);
        chk("spurious_rdata", if_rdata_o | d_rdata_o, 32'd0);
        @(posedge clock_i); #1;
        mem_ack_i = 1'b0;
        #3;
        chk("spurious_idle", 32'(mem_req_o), 32'd0);
        @(posedge clock_i); #1;

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(1, 3));
            if_req_i  = r[0];
            d_req_i   = r[1];
            if_addr_i = {$urandom, 2'b00} ;
            d_addr_i  = {$urandom, 2'b00};
            d_we_i    = 1'($urandom_range(0, 1));
            d_be_i    = 4'($urandom_range(1, 15));
            d_wdata_i = $urandom;
            rd        = $urandom;
            run_txn(int'($urandom_range(0, TIMEOUT + 2)), rd, g);
        end
        if_req_i = 1'b0; d_req_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
